// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART receiver.
// Receiver states, parity mode encodings and the baud divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic int calc_div(
    input int clk_freq,
    input int baud_rate,
    input int oversample
  );
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side valid/ready port of the buffered UART receiver.
// The receiver is the master; the consumer is the slave.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] out_data;
  logic                 out_frame_err;
  logic                 out_parity_err;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_data,
    output out_frame_err,
    output out_parity_err,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_frame_err,
    input  out_parity_err,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO with valid/ready read port.
// A push into a full FIFO is accepted only if a pop happens alongside.
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  input  logic                     ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PONE = AW'(1);
  localparam logic [AW:0]   CONE = (AW+1)'(1);
  localparam logic [AW:0]   CFULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             full;
  logic             pop;
  logic             wr;

  assign valid = count != '0;
  assign full  = count == CFULL;
  assign pop   = valid && ready;
  assign wr    = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign head  = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + PONE;
      end
      if (pop)
        rptr <= rptr + PONE;
      if (wr && !pop)
        count <= count + CONE;
      else if (pop && !wr)
        count <= count - CONE;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority vote, parity and
// framing checks, buffered through a FWFT FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic [1:0]                    parity_mode,
  uart_rx_fifo_if.master                bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          rx_busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int FW  = DATA_BITS + 2;

  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_fifo: baud divisor below 1");
  end

  logic [1:0]           sync;
  logic                 rxs;
  logic [TW-1:0]        tcnt;
  logic                 tick;
  logic [SW-1:0]        scnt;
  logic                 v_lo;
  logic                 v_mid;
  logic                 vote;
  logic                 decide;
  logic                 start_det;
  rx_state_t            state;
  logic [1:0]           mode;
  logic                 par_en;
  logic [DATA_BITS-1:0] shift;
  logic [BW-1:0]        bcnt;
  logic                 perr;
  logic                 push;
  logic [FW-1:0]        push_data;
  logic [FW-1:0]        head;
  logic                 drop;

  assign rxs = sync[1];

  always_ff @(posedge clk) begin
    if (rst)
      sync <= 2'b11;
    else
      sync <= {sync[0], rx};
  end

  assign tick = tcnt == T_LAST;

  always_ff @(posedge clk) begin
    if (rst)
      tcnt <= '0;
    else
      tcnt <= tick ? '0 : tcnt + T_ONE;
  end

  assign start_det = (state == IDLE) && tick && !rxs;
  assign decide    = tick && (scnt == S_HI);
  assign vote      = (v_lo & v_mid) | (v_lo & rxs) | (v_mid & rxs);

  // Detection tick is count 0, so decisions land near mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt  <= '0;
      v_lo  <= 1'b1;
      v_mid <= 1'b1;
    end else begin
      if (start_det)
        scnt <= '0;
      else if (tick)
        scnt <= (scnt == S_LAST) ? '0 : scnt + S_ONE;
      if (tick && scnt == S_LO)
        v_lo <= rxs;
      if (tick && scnt == S_MID)
        v_mid <= rxs;
    end
  end

  assign par_en = (mode == PAR_EVEN) || (mode == PAR_ODD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode    <= PAR_NONE;
      shift   <= '0;
      bcnt    <= '0;
      perr    <= 1'b0;
      rx_busy <= 1'b0;
    end else begin
      rx_busy <= state != IDLE;
      unique case (state)
        IDLE: if (start_det) begin
          state <= START;
          mode  <= parity_mode;
          bcnt  <= '0;
          perr  <= 1'b0;
        end
        START: if (decide)
          state <= vote ? IDLE : DATA;
        DATA: if (decide) begin
          shift <= {vote, shift[DATA_BITS-1:1]};
          if (bcnt == B_LAST)
            state <= par_en ? PARITY : STOP;
          else
            bcnt <= bcnt + B_ONE;
        end
        PARITY: if (decide) begin
          perr  <= (^shift ^ vote) != (mode == PAR_ODD);
          state <= STOP;
        end
        STOP: if (decide)
          state <= vote ? IDLE : BREAK;
        BREAK: if (rxs)
          state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign push      = (state == STOP) && decide;
  assign push_data = {perr, ~vote, shift};

  uart_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .head      (head),
    .valid     (bus.out_valid),
    .ready     (bus.out_ready),
    .count     (fifo_count),
    .drop      (drop)
  );

  assign bus.out_data       = head[DATA_BITS-1:0];
  assign bus.out_frame_err  = head[DATA_BITS];
  assign bus.out_parity_err = head[DATA_BITS+1];

  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clr_overflow)
      overflow <= 1'b0;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised, buffered UART receiver; next generation of the team's single-byte receiver. Oversamples `rx` with majority voting and supports configurable data width and runtime-selectable parity. Returns LSB-first words, with framing and parity error flags, through an internal FWFT FIFO with a valid/ready read port. Sits between the pad-side `rx` line and the UART controller, replacing its ring buffer.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit period; even, ≥8.
- `DATA_BITS`, 8: data bits per frame; 5..9.
- `FIFO_DEPTH`, 16: FIFO entries; power of 2, ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx`  in  1  asynchronous serial input; idle high.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- `out_data`  out  DATA_BITS  FIFO head data.
- `out_frame_err`  out  1  head word's stop bit sampled 0.
- `out_parity_err`  out  1  head word's parity mismatch.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer pops the head when `out_valid && out_ready`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries held.
- `overflow`  out  1  sticky; a word was dropped because the FIFO was full.
- `clr_overflow`  in  1  clears `overflow`.
- `rx_busy`  out  1  receiver is not in IDLE.

## Operation
- **Synchroniser:** `rx` passes through 2 flops, both reset to 1. All logic uses the synchronised value `rxs`.
- **Tick generator:**
  - Divisor `DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE)`, integer division. Elaboration fails if `DIV < 1`.
  - The counter free-runs 0..DIV-1; `tick` asserts for one clk when the count is DIV-1.
- **Sample counter:** 0..OVERSAMPLE-1, advances on `tick`. It is zeroed on IDLE→START.
- **Bit value:** majority of `rxs` taken at sample counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit is decided on the tick at OVERSAMPLE/2+1, called the decision tick.
- **State machine:**
  - **IDLE:** on a tick with `rxs==0`, go to START. Latch `parity_mode`; a mid-frame change has no effect.
  - **START:** at the decision tick, a vote of 0 goes to DATA. A vote of 1 is a false start: return to IDLE and push nothing.
  - **DATA:** one bit per bit period, LSB first, into `shift[DATA_BITS-1:0]`. After bit DATA_BITS-1, go to PARITY if the latched mode is even or odd, otherwise to STOP.
  - **PARITY:** vote compared with the expected bit. Even: the XOR of data and parity must be 0. Odd: it must be 1.
  - **STOP:** at the decision tick, push `{parity_err, frame_err, data}`, with `frame_err` = (vote==0).
    - If `frame_err==0`, go to IDLE immediately; the remaining half bit is used for resynchronisation.
    - If `frame_err==1`, go to BREAK.
  - **BREAK:** wait for `rxs==1`, then go to IDLE. No further pushes while `rxs` stays low.
- **FIFO (FWFT):**
  - `out_*` always present the head entry. They are meaningful only while `out_valid` is high.
  - Push when full and no pop in the same cycle: the word is dropped and `overflow` is set.
  - Push when full with a pop in the same cycle: the push is accepted and the count is unchanged.
  - Pop when empty: ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- **overflow:** set has priority over `clr_overflow` in the same cycle.
- **Reset:** takes effect at any point, including mid-frame.
  - State returns to IDLE and any partial frame is discarded.
  - The FIFO empties; pointers and count go to 0.
  - The tick and sample counters go to 0.
- **Reset values:** `out_valid`=0, `fifo_count`=0, `overflow`=0, `rx_busy`=0. `out_data`, `out_frame_err` and `out_parity_err` are 0 because the FIFO storage head is cleared.

## Timing
- Bit period is `OVERSAMPLE*DIV` clk.
- Start detection occurs within 1 tick plus 2 clk (synchroniser) of the falling edge.
- Each bit is decided at roughly 9/16 of the bit period for OVERSAMPLE=16.
- The push happens on the clk edge of the stop-bit decision tick. `out_valid` and `fifo_count` update on the next edge, giving 1 clk latency.
- A pop takes effect on the clk edge where `out_valid && out_ready`. The new head appears on the following cycle.
- `out_ready` may be held high continuously. With that, one word is consumed per cycle and there are no combinational paths from `out_ready` to `out_valid`.
- `rx_busy` is registered and goes high one clk after IDLE→START.

## Structure
- Package `uart_pkg`:
  - state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP, BREAK);
  - parity constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - the DIV computation function.
- Sub-module `uart_sync_fifo`, with parameters WIDTH and DEPTH: FWFT, valid/ready, `count` output, full-with-pop push behaviour as specified. Instantiated here with WIDTH = DATA_BITS+2.
- The synchroniser, tick generator, sampler and FSM are implemented in `uart_rx_fifo` itself.

## Test plan
All scenarios use CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, DATA_BITS=8 and FIFO_DEPTH=4, giving DIV=10 and 160 clk per bit.
- **Basic receive:** 0xA5, parity none, `out_ready`=0 → `out_valid`=1, `out_data`=0xA5, both error flags 0, `fifo_count`=1.
- **Parity:** 0x07 with even parity, correct bit=1 → `out_parity_err`=0. The same frame with odd parity mode → `out_parity_err`=1, data still 0x07.
- **Framing error and break:** 0x3C, then hold `rx` low for 3 bit periods → one word 0x3C with `out_frame_err`=1 and no further pushes. After `rx` returns high, 0x55 is received cleanly.
- **Glitch rejection:** 40-clk low pulse on idle `rx` → no push, `rx_busy` returns to 0. A 1-sample glitch in the middle of data bit 3 of 0x00 → `out_data`=0x00.
- **Overflow:** 5 back-to-back frames 0x01..0x05 with `out_ready`=0 → `fifo_count`=4, `overflow`=1, and pops return 0x01..0x04. `clr_overflow` then clears `overflow`.
- **Reset mid-frame:** assert `rst` for 1 clk during data bit 4 with 2 words queued → `fifo_count`=0, `out_valid`=0, `rx_busy`=0. The next full frame 0xC3 is received correctly.
